// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch front end for the 16-bit processor.
// Issues sequential addresses to a 1-cycle-latency synchronous instruction
// memory, captures returned words into a small prefetch FIFO and hands them
// to decode over a valid/ready handshake. Branch/jump redirects flush all
// prefetched and in-flight words.
//
// Optional feature macro: IFETCH_FAST_REDIRECT_EN
//   defined   -> redirect_pc drives mem_addr combinationally in the redirect
//                cycle, saving one cycle of redirect penalty.
//   undefined -> mem_addr is purely registered (3-cycle redirect penalty).
module instr_fetch_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_q,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [DATA_W-1:0]          instr,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PC_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};
    // One extra bit so count + inflight can never wrap in the compare.
    localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W+1)'(DEPTH);

    // Fetch state
    logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
    logic              inflight_q,    inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    // Prefetch FIFO state
    logic [DATA_W-1:0] word_q [DEPTH];
    logic [DATA_W-1:0] word_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // Handshake / control
    logic [CNT_W:0]    credit_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              write_en_s;

    // Conservative credit: a same-cycle pop is ignored so the FIFO never overflows.
    always_comb begin
        credit_s   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        issue_s    = (credit_s < DEPTH_C);
        push_s     = inflight_q;
        pop_s      = (count_q != CNT_ZERO) && instr_ready;
        write_en_s = push_s && !redirect;
    end

    // Next-state for fetch pointer, in-flight tracking and FIFO pointers/count.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect) begin
            // Redirect wins over issue, push and pop: everything queued is dropped.
            rd_ptr_d = PTR_ZERO;
            wr_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
`ifdef IFETCH_FAST_REDIRECT_EN
            // Target address went out on mem_addr this cycle, so it is in flight.
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_pc;
            fetch_pc_d    = redirect_pc + PC_ONE;
`else
            // Word returning next cycle belongs to the old path and is discarded.
            inflight_d    = 1'b0;
            fetch_pc_d    = redirect_pc;
`endif
        end else begin
            if (issue_s) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + PC_ONE;
            end else begin
                inflight_d    = 1'b0;
                fetch_pc_d    = fetch_pc_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Next-state for FIFO storage: the returning word lands at the write pointer.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (write_en_s && (wr_ptr_q == PTR_W'(i))) begin
                word_d[i] = mem_q;
                pc_d[i]   = inflight_pc_q;
            end else begin
                word_d[i] = word_q[i];
                pc_d[i]   = pc_q[i];
            end
        end
    end

    // State registers with asynchronous active-low reset clearing everything.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= PC_ZERO;
            inflight_q    <= 1'b0;
            inflight_pc_q <= PC_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            wr_ptr_q      <= PTR_ZERO;
            count_q       <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= WORD_ZERO;
                pc_q[i]   <= PC_ZERO;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= word_d[i];
                pc_q[i]   <= pc_d[i];
            end
        end
    end

    // Output drive: memory address and FIFO head presentation.
    always_comb begin
`ifdef IFETCH_FAST_REDIRECT_EN
        if (redirect) begin
            mem_addr = redirect_pc;
        end else begin
            mem_addr = fetch_pc_q;
        end
`else
        mem_addr = fetch_pc_q;
`endif
        instr_valid = (count_q != CNT_ZERO);
        instr       = word_q[rd_ptr_q];
        instr_pc    = pc_q[rd_ptr_q];
        fifo_count  = count_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// The memory model returns 16'hA000 + address one cycle after the address.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [11:0] mem_addr;
    logic [15:0] mem_q;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic [2:0]  fifo_count;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef IFETCH_FAST_REDIRECT_EN
    localparam int PEN = 2;
`else
    localparam int PEN = 3;
`endif

    instr_fetch_unit #(.ADDR_W(12), .DATA_W(16), .DEPTH(4)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_q       (mem_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [11:0] a);
        return 16'hA000 + {4'h0, a};
    endfunction

    // Synchronous instruction ROM, one cycle latency
    always @(posedge clk) mem_q <= rom_word(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] epc;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 12'h000;
        instr_ready = 1'b1;
        #1;
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_valid", instr_valid, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_count", fifo_count, 32'h0);

        // Release reset: this negedge is inside cycle 0
        @(negedge clk);
        reset = 1'b1;
        chk("c0_mem_addr", mem_addr, 32'h0);
        chk("c0_valid", instr_valid, 32'h0);
        step();
        chk("c1_valid", instr_valid, 32'h0);
        chk("c1_mem_addr", mem_addr, 32'h1);
        step();
        chk("c2_valid", instr_valid, 32'h1);
        chk("c2_instr", instr, 32'hA000);
        chk("c2_pc", instr_pc, 32'h0);
        chk("c2_count", fifo_count, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("seq_valid", instr_valid, 32'h1);
            chk("seq_pc", instr_pc, i);
            chk("seq_instr", instr, 32'hA000 + i);
        end

        // Asynchronous reset mid-stream, between edges
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", instr_valid, 32'h0);
        chk("async_count", fifo_count, 32'h0);
        chk("async_mem_addr", mem_addr, 32'h0);
        chk("async_instr", instr, 32'h0);
        chk("async_pc", instr_pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("rr_c1_valid", instr_valid, 32'h0);
        step();
        chk("rr_c2_valid", instr_valid, 32'h1);
        chk("rr_c2_pc", instr_pc, 32'h0);
        chk("rr_c2_instr", instr, 32'hA000);

        // Backpressure for 10 cycles
        instr_ready = 1'b0;
        repeat (10) step();
        chk("bp_count", fifo_count, 32'h4);
        chk("bp_mem_addr", mem_addr, 32'h4);
        chk("bp_valid", instr_valid, 32'h1);
        chk("bp_pc", instr_pc, 32'h0);
        chk("bp_instr", instr, 32'hA000);
        instr_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("drain_valid", instr_valid, 32'h1);
            chk("drain_pc", instr_pc, i);
            chk("drain_instr", instr, 32'hA000 + i);
        end
        chk("steady_count", fifo_count, 32'h2);

        // Build up three entries with a read in flight, then redirect
        instr_ready = 1'b0;
        step();
        chk("pre_redir_count", fifo_count, 32'h3);
        redirect    = 1'b1;
        redirect_pc = 12'h100;
        instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        chk("redir_k1_count", fifo_count, 32'h0);
`ifdef IFETCH_FAST_REDIRECT_EN
        chk("redir_k1_mem_addr", mem_addr, 32'h101);
`else
        chk("redir_k1_mem_addr", mem_addr, 32'h100);
`endif
        for (int i = 1; i < PEN; i++) begin
            chk("redir_bubble_valid", instr_valid, 32'h0);
            step();
        end
        chk("redir_tgt_valid", instr_valid, 32'h1);
        chk("redir_tgt_pc", instr_pc, 32'h100);
        chk("redir_tgt_instr", instr, 32'hA100);
        step();
        chk("redir_next_valid", instr_valid, 32'h1);
        chk("redir_next_pc", instr_pc, 32'h101);
        chk("redir_next_instr", instr, 32'hA101);

        // Back-to-back redirects: the second one wins
        redirect    = 1'b1;
        redirect_pc = 12'h050;
        step();
        redirect_pc = 12'h200;
        step();
        redirect = 1'b0;
        for (int i = 1; i < PEN; i++) begin
            chk("b2b_bubble_valid", instr_valid, 32'h0);
            step();
        end
        chk("b2b_valid", instr_valid, 32'h1);
        chk("b2b_pc", instr_pc, 32'h200);
        chk("b2b_instr", instr, 32'hA200);

        // PC wrap-around
        redirect    = 1'b1;
        redirect_pc = 12'hFFE;
        step();
        redirect = 1'b0;
        for (int i = 1; i < PEN; i++) begin
            chk("wrap_bubble_valid", instr_valid, 32'h0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            epc = 12'hFFE + i[11:0];
            chk("wrap_valid", instr_valid, 32'h1);
            chk("wrap_pc", instr_pc, {20'h0, epc});
            chk("wrap_instr", instr, {16'h0, rom_word(epc)});
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Instruction fetch front end of the 16-bit processor, upstream of decode/control.
- Drives the address of the synchronous instruction memory (1-cycle read latency) and captures the returned words into a small prefetch FIFO.
- Presents each instruction, with its address, to the decode stage over a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage; a redirect flushes all prefetched and in-flight words.

## Interface
Parameters:
- ADDR_W, 12, instruction address width (PC width).
- DATA_W, 16, instruction word width.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_addr  out  ADDR_W  address to instruction memory, sampled by memory on every rising edge.
- mem_q  in  DATA_W  memory data; valid the cycle after its address was presented.
- redirect  in  1  taken branch/jump this cycle.
- redirect_pc  in  ADDR_W  new fetch address; qualified by redirect.
- instr_valid  out  1  FIFO head holds a valid instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instr  out  DATA_W  FIFO head instruction word.
- instr_pc  out  ADDR_W  address of instr.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- State:
  - fetch_pc (ADDR_W).
  - inflight bit plus inflight_pc: a read was issued last cycle.
  - FIFO of {word, pc} with read pointer, write pointer and count.
- mem_addr = fetch_pc, combinational from the register.
- Issue: when count + inflight < DEPTH, the current fetch_pc is issued. That edge sets inflight=1, inflight_pc=fetch_pc and fetch_pc = fetch_pc+1. Otherwise inflight=0 and fetch_pc holds.
- Credit counting is conservative and ignores a same-cycle pop, so the FIFO can never overflow.
- Push: when inflight=1, {mem_q, inflight_pc} is written at the edge.
- Pop: when instr_valid && instr_ready, the head is removed at the edge.
- Push and pop in the same cycle leaves count unchanged.
- Pop with instr_valid=0 is ignored.
- instr_valid = (count != 0). instr and instr_pc come from the head entry and hold their value while instr_ready=0.
- PC arithmetic is modulo 2^ADDR_W: 0xFFF + 1 = 0x000, and there is no fault.
- Redirect has priority over issue, push and pop in the same cycle. At that edge:
  - FIFO is cleared (count=0, pointers=0).
  - inflight=0, so the word returning next cycle is discarded.
  - fetch_pc = redirect_pc.
- A pop in a redirect cycle still counts as accepted by decode; the remaining entries are discarded.
- Back-to-back redirects: the last one wins.
- Reset (reset=0, no clock needed) forces:
  - fetch_pc=0, inflight=0, count=0, pointers=0, all FIFO storage=0.
  - Output values: mem_addr=0, instr_valid=0, instr=0, instr_pc=0, fifo_count=0.

## Timing
- Cycle 0 is the first cycle with reset=1:
  - Address 0 is issued in cycle 0, the word returns in cycle 1 and is pushed at the end of cycle 1.
  - instr_valid=1 from cycle 2.
- Steady state with instr_ready held high: one instruction per cycle, consecutive PCs, no bubbles.
- Backpressure: with instr_ready=0, the FIFO fills to DEPTH; fetch_pc then stops at head_pc+DEPTH. No word is lost or duplicated.
- Redirect asserted in cycle k:
  - instr_valid=0 in cycle k+1.
  - mem_addr=redirect_pc in cycle k+1.
  - The target instruction is valid in cycle k+3, a 3-cycle penalty.
- fifo_count updates on the same edge as push/pop/flush.

## Configuration
- IFETCH_FAST_REDIRECT_EN defined:
  - In a redirect cycle, mem_addr = redirect_pc combinationally and the target address counts as issued in cycle k.
  - The edge sets inflight=1, inflight_pc=redirect_pc and fetch_pc=redirect_pc+1, with the FIFO still flushed.
  - The target instruction is valid in cycle k+2.
  - This adds a combinational path from redirect to mem_addr.
- Undefined: mem_addr is purely registered; redirect timing is as in Timing (valid at k+3).

## Test plan
- Reset release, ROM[i]=16'hA000+i, instr_ready=1 -> instr_valid rises in cycle 2 with instr=0xA000, instr_pc=0; then 0xA001, 0xA002, … on consecutive cycles.
- instr_ready=0 for 10 cycles after the first valid -> fifo_count saturates at 4 and mem_addr holds at 4. With instr_ready=1 afterwards, pcs 0,1,2,3,4,5 appear contiguous with no gaps or repeats.
- redirect=1, redirect_pc=0x100 while fifo_count=3 and a read is in flight -> cycle k+1 shows instr_valid=0 and fifo_count=0. instr_pc=0x100 with instr=ROM[0x100] is valid at k+3 (k+2 with IFETCH_FAST_REDIRECT_EN). The in-flight word never appears.
- redirect in cycles k and k+1, to 0x050 then 0x200 -> the first instruction delivered is from 0x200.
- Wrap: redirect_pc=0xFFE, instr_ready=1 -> instr_pc sequence 0xFFE, 0xFFF, 0x000, 0x001.
- reset driven low mid-stream between clock edges -> instr_valid, fifo_count, mem_addr, instr and instr_pc go to 0 immediately. After release, fetch restarts at address 0 with first valid in cycle 2.
